seq_mult_hs: RTL and testbench
==============================

# seq_mult_hs

Parametrised radix-2 shift-add sequential multiplier with valid/ready handshakes on input and output. Controller and datapath are in one block. Adds signed/unsigned mode, a zero-operand shortcut, early termination on the remaining multiplier bits, result back-pressure and abort. Sits between an operand producer and a result consumer in the arithmetic subsystem, one multiplication in flight at a time.

## Interface
- WIDTH, 16, operand width in bits, ≥2; product is 2*WIDTH bits.
- CW, $clog2(WIDTH), internal bit-counter width (derived, not overridden).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- src_valid  in  1  operand pair and mode valid.
- src_ready  out  1  block can accept operands.
- multiplier  in  WIDTH  operand A, sampled on input handshake.
- multiplicand  in  WIDTH  operand B, sampled on input handshake.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on input handshake.
- abort  in  1  synchronous; drops the current operation.
- dst_valid  out  1  product valid.
- dst_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  result register.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE. The reset state is IDLE.
- src_ready = (state==IDLE) && !abort. Input handshake = src_valid && src_ready.
- Handshake in IDLE, with either operand zero: go to DONE. The product register loads 0.
- Handshake in IDLE, both operands nonzero: go to CALC and load the following registers.
  - neg = signed_mode && (A[W-1] ^ B[W-1]).
  - mplr = |A| (WIDTH bits). Magnitude is taken only when signed_mode is set.
  - mcand = |B| zero-extended to 2W bits.
  - acc = 0, cnt = 0.
  - |−2^(W-1)| = 2^(W-1) fits in W bits unsigned, so no overflow occurs.
- Each CALC cycle performs one step:
  - sum = acc + (mplr[0] ? mcand : 0).
  - acc←sum; mcand←mcand<<1; mplr←mplr>>1; cnt←cnt+1.
- CALC exits when (mplr>>1)==0 or cnt==WIDTH-1. On that same edge:
  - product ← neg ? −sum : sum, computed mod 2^(2W).
  - State goes to DONE.
- DONE: dst_valid=1. When dst_valid && dst_ready, go to IDLE. product and dst_valid stay stable until that handshake.
- product holds its last value in IDLE and is never cleared except by reset.
- abort in CALC or DONE: go to IDLE on the next edge. dst_valid drops and the partial result is discarded. product is unchanged. abort in IDLE blocks acceptance.
- An abort and a dst handshake in the same DONE cycle both lead to IDLE. The result is counted as consumed.
- Unsigned results are exact over 2W bits. Signed results are exact two's complement over 2W bits.

## Timing
- Reset values: state IDLE, product 0, dst_valid 0, busy 0, src_ready 1 (abort low), all internal registers 0.
- Reset takes effect immediately whenever asserted, including mid-CALC and in DONE. After release the block is in IDLE.
- Let k = index of the highest set bit of mplr. CALC lasts k+1 cycles. dst_valid rises k+2 clocks after the input-handshake edge.
- Minimum latency is 2 clocks (k=0). Maximum is WIDTH+1 clocks.
- Zero operand: dst_valid rises 1 clock after the handshake edge.
- Throughput with dst_ready held high: a new input can be accepted the cycle after the output handshake. No overlap.
- src_ready, dst_valid and busy are decoded from registered state only. There is no combinational path from src_valid or dst_ready to any output.

## Test plan
- Unsigned, WIDTH=16, A=0xFFFF, B=0xFFFF, dst_ready=1 → dst_valid 17 clocks after accept, product=0xFFFE0001, then src_ready=1 on the next cycle.
- Signed, A=−3 (0xFFFD), B=5 → 2 CALC cycles, dst_valid 3 clocks after accept, product=0xFFFFFFF1. Also A=0x8000, B=0x8000 signed → product=0x40000000 at 17 clocks. The same operands unsigned → 0x40000000.
- Zero shortcut: A=0, B=0x1234 → dst_valid 1 clock after accept, product=0. busy is high for exactly 1 cycle when dst_ready=1.
- Back-pressure: A=6, B=7, dst_ready=0 for 5 cycles → dst_valid held, product=42 stable, src_ready=0 throughout. Accept completes when dst_ready rises.
- Abort: assert abort in the 3rd CALC cycle of 0xFFFF×0x0003 → next cycle IDLE, dst_valid=0, product keeps the previous result. src_valid held during abort is not accepted.
- Reset mid-operation: assert reset in CALC and in DONE → outputs go to reset values immediately. After release, 9×9 returns 81 with normal latency.

Source files
------------

// File: rtl/seq_mult_hs_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// The slave side is the multiplier; the master side is the producer/consumer pair.
interface seq_mult_hs_if #(
  parameter int WIDTH = 16
);
  logic                 src_valid;
  logic                 src_ready;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic                 signed_mode;
  logic                 abort;
  logic                 dst_valid;
  logic                 dst_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output src_valid, multiplier, multiplicand, signed_mode, abort, dst_ready,
    input  src_ready, dst_valid, product, busy
  );

  modport slave (
    input  src_valid, multiplier, multiplicand, signed_mode, abort, dst_ready,
    output src_ready, dst_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_hs.sv
// Radix-2 shift-add sequential multiplier with valid/ready on both sides,
// signed/unsigned mode, zero shortcut, early exit and abort.
module seq_mult_hs #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  seq_mult_hs_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [WIDTH-1:0]        mplr;
  logic [PW-1:0]           mcand;
  logic [PW-1:0]           acc;
  logic [PW-1:0]           sum;
  logic [CW-1:0]           cnt;
  logic                    neg;
  logic [PW-1:0]           product_r;

  logic                    src_rdy;
  logic                    dst_vld;
  logic                    src_hs;
  logic                    dst_hs;
  logic                    op_zero;
  logic                    calc_last;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;
  logic                    neg_in;

  // Magnitude of an operand; only two's-complement inputs are ever negated.
  // |-2^(W-1)| wraps back to 2^(W-1), which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [PW-1:0] cond_negate(input logic [PW-1:0] v,
                                                input logic          n);
    return n ? -v : v;
  endfunction

  assign src_rdy   = (state == IDLE) && !bus.abort;
  assign dst_vld   = (state == DONE);
  assign src_hs    = bus.src_valid && src_rdy;
  assign dst_hs    = dst_vld && bus.dst_ready;
  assign op_zero   = (bus.multiplier == '0) || (bus.multiplicand == '0);
  assign neg_in    = bus.signed_mode && (bus.multiplier[WIDTH-1] ^ bus.multiplicand[WIDTH-1]);
  assign mag_a     = magnitude(bus.multiplier, bus.signed_mode);
  assign mag_b     = magnitude(bus.multiplicand, bus.signed_mode);

  assign sum       = acc + (mplr[0] ? mcand : '0);
  assign calc_last = (mplr[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));

  assign bus.src_ready = src_rdy;
  assign bus.dst_valid = dst_vld;
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (src_hs) state_nxt = op_zero ? DONE : CALC;
      end
      CALC: begin
        if (bus.abort)     state_nxt = IDLE;
        else if (calc_last) state_nxt = DONE;
      end
      DONE: begin
        // Abort together with a consumer handshake still counts as consumed.
        if (bus.abort || dst_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load on acceptance / one shift-add step per CALC cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mplr      <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product_r <= '0;
    end else if (src_hs) begin
      if (op_zero) begin
        product_r <= '0;
      end else begin
        neg   <= neg_in;
        mplr  <= mag_a;
        mcand <= {{WIDTH{1'b0}}, mag_b};
        acc   <= '0;
        cnt   <= '0;
      end
    end else if (state == CALC && !bus.abort) begin
      acc   <= sum;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CW'(1);
      if (calc_last) product_r <= cond_negate(sum, neg);
    end
  end
endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs: per-cycle comparison against an arithmetic model,
// plus directed cases with hand-computed products and latencies.
module tb_seq_mult_hs;
  localparam int W  = 16;
  localparam int PW = 2 * W;

  localparam int P_IDLE = 0;
  localparam int P_CALC = 1;
  localparam int P_DONE = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic chk_en;

  seq_mult_hs_if #(.WIDTH(W)) bus ();

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exact product over 2W bits from plain integer multiplication.
  function automatic logic [PW-1:0] ref_product(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic         s);
    longint va;
    longint vb;
    if (s) begin
      va = longint'($signed(a));
      vb = longint'($signed(b));
    end else begin
      va = longint'(a);
      vb = longint'(b);
    end
    return PW'(va * vb);
  endfunction

  // CALC length: one cycle per multiplier bit up to its highest set bit.
  function automatic int calc_cycles(input logic [W-1:0] a, input logic s);
    longint v;
    int     k;
    v = s ? longint'($signed(a)) : longint'(a);
    if (v < 0) v = -v;
    k = 0;
    for (int i = 0; i < W; i++) if (v[i]) k = i;
    return k + 1;
  endfunction

  // Behavioural model: phase plus remaining-cycle count, result from ref_product.
  int            m_phase;
  int            m_left;
  logic [PW-1:0] m_prod;
  logic [PW-1:0] m_pending;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase   <= P_IDLE;
      m_left    <= 0;
      m_prod    <= '0;
      m_pending <= '0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (bus.src_valid && !bus.abort) begin
            if (bus.multiplier == '0 || bus.multiplicand == '0) begin
              m_prod  <= '0;
              m_phase <= P_DONE;
            end else begin
              m_pending <= ref_product(bus.multiplier, bus.multiplicand, bus.signed_mode);
              m_left    <= calc_cycles(bus.multiplier, bus.signed_mode);
              m_phase   <= P_CALC;
            end
          end
        end
        P_CALC: begin
          if (bus.abort) begin
            m_phase <= P_IDLE;
          end else if (m_left == 1) begin
            m_prod  <= m_pending;
            m_phase <= P_DONE;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: begin
          if (bus.abort || bus.dst_ready) m_phase <= P_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_src_ready", 64'(bus.src_ready), 64'(m_phase == P_IDLE && !bus.abort));
      check("cyc_busy",      64'(bus.busy),      64'(m_phase != P_IDLE));
      check("cyc_dst_valid", 64'(bus.dst_valid), 64'(m_phase == P_DONE));
      check("cyc_product",   64'(bus.product),   64'(m_prod));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((bus.busy || !bus.src_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idle", 64'(bus.busy), 64'(0));
  endtask

  // Issues one operation and measures latency (clocks from the accepting edge,
  // counting that edge) until dst_valid; completes the output side if dst_ready.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [PW-1:0] exp_p, input int exp_lat,
                       input string nm, output int busy_cyc);
    int lat;
    wait_idle();
    bus.multiplier   = a;
    bus.multiplicand = b;
    bus.signed_mode  = s;
    bus.src_valid    = 1'b1;
    @(posedge clk); #1;
    bus.src_valid = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    @(negedge clk);
    while (!bus.dst_valid && lat < 4 * W) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_product"}, 64'(bus.product), 64'(exp_p));
    if (bus.dst_ready) begin
      while (bus.busy && busy_cyc < 4 * W) begin
        busy_cyc++;
        @(negedge clk);
      end
      check({nm, "_src_ready_next"}, 64'(bus.src_ready), 64'(1));
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << (W - 1);
      3:       return W'($urandom_range(1, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int            bc;
    logic [PW-1:0] prev;
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b1;
    reset   = 1'b0;
    bus.src_valid    = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    bus.signed_mode  = 1'b0;
    bus.abort        = 1'b0;
    bus.dst_ready    = 1'b1;

    // Pin the model against hand-computed values.
    check("model_ffff_u",   64'(ref_product(16'hFFFF, 16'hFFFF, 1'b0)), 64'h0000_0000_FFFE_0001);
    check("model_m3x5_s",   64'(ref_product(16'hFFFD, 16'h0005, 1'b1)), 64'h0000_0000_FFFF_FFF1);
    check("model_8000_s",   64'(ref_product(16'h8000, 16'h8000, 1'b1)), 64'h0000_0000_4000_0000);
    check("model_m3_cycles", 64'(calc_cycles(16'hFFFD, 1'b1)), 64'(2));
    check("model_8000_cycles", 64'(calc_cycles(16'h8000, 1'b1)), 64'(16));

    repeat (2) @(negedge clk);
    check("reset_src_ready", 64'(bus.src_ready), 64'(1));
    check("reset_product",   64'(bus.product),   64'(0));
    check("reset_busy",      64'(bus.busy),      64'(0));
    check("reset_dst_valid", 64'(bus.dst_valid), 64'(0));
    #2 reset = 1'b1;

    do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 17, "u_ffff", bc);
    do_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 3,  "s_m3x5", bc);
    do_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 17, "s_8000", bc);
    do_op(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 17, "u_8000", bc);
    do_op(16'h0000, 16'h1234, 1'b0, 32'h0000_0000, 1,  "zero",   bc);
    check("zero_busy_cycles", 64'(bc), 64'(1));

    // Back-pressure: result held for five cycles with the consumer stalled.
    bus.dst_ready = 1'b0;
    do_op(16'd6, 16'd7, 1'b0, 32'd42, 4, "bp", bc);
    for (int i = 0; i < 5; i++) begin
      check("bp_dst_valid", 64'(bus.dst_valid), 64'(1));
      check("bp_product",   64'(bus.product),   64'(42));
      check("bp_src_ready", 64'(bus.src_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.dst_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(bus.dst_valid), 64'(1));
    @(negedge clk);
    check("bp_done_valid",     64'(bus.dst_valid), 64'(0));
    check("bp_done_src_ready", 64'(bus.src_ready), 64'(1));

    // Abort in the third CALC cycle, with src_valid held high through it.
    prev = bus.product;
    wait_idle();
    bus.multiplier   = 16'hFFFF;
    bus.multiplicand = 16'h0003;
    bus.signed_mode  = 1'b0;
    bus.src_valid    = 1'b1;
    @(posedge clk); #1;
    bus.src_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.abort     = 1'b1;
    bus.src_valid = 1'b1;
    @(negedge clk);
    check("abort_busy_before", 64'(bus.busy),      64'(1));
    check("abort_src_ready",   64'(bus.src_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy_after", 64'(bus.busy),      64'(0));
    check("abort_dst_valid",  64'(bus.dst_valid), 64'(0));
    check("abort_product",    64'(bus.product),   64'(prev));
    @(posedge clk); #1;
    bus.abort     = 1'b0;
    bus.src_valid = 1'b0;
    @(negedge clk);
    check("abort_not_accepted", 64'(bus.busy), 64'(0));

    // Reset while in CALC.
    wait_idle();
    bus.multiplier   = 16'hFFFF;
    bus.multiplicand = 16'hFFFF;
    bus.src_valid    = 1'b1;
    @(posedge clk); #1;
    bus.src_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_calc_busy",      64'(bus.busy),      64'(0));
    check("rst_calc_dst_valid", 64'(bus.dst_valid), 64'(0));
    check("rst_calc_src_ready", 64'(bus.src_ready), 64'(1));
    check("rst_calc_product",   64'(bus.product),   64'(0));
    @(negedge clk);
    #2 reset = 1'b1;

    // Reset while in DONE.
    bus.dst_ready = 1'b0;
    do_op(16'd6, 16'd7, 1'b0, 32'd42, 4, "pre_rst", bc);
    #2 reset = 1'b0;
    #1;
    check("rst_done_dst_valid", 64'(bus.dst_valid), 64'(0));
    check("rst_done_busy",      64'(bus.busy),      64'(0));
    check("rst_done_product",   64'(bus.product),   64'(0));
    @(negedge clk);
    #2 reset = 1'b1;
    bus.dst_ready = 1'b1;
    do_op(16'd9, 16'd9, 1'b0, 32'd81, 5, "after_rst", bc);

    // Randomised traffic; the per-cycle checker follows the model throughout.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.src_valid    = ($urandom_range(0, 2) != 0);
      bus.multiplier   = rand_op();
      bus.multiplicand = rand_op();
      bus.signed_mode  = 1'($urandom_range(0, 1));
      bus.abort        = ($urandom_range(0, 24) == 0);
      bus.dst_ready    = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.src_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.dst_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
